// File: rtl/i2c_sram_master.sv
// I2C master: one 16-bit SRAM word write or read per command on open-drain sda / push-pull scl.
// Response 38 bit slots (4*CLK_DIV clk each) after accept, fewer on NACK; cmd_ready is low while busy and commands offered then are dropped.
module i2c_sram_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_dev_addr,
  input  logic [7:0]  cmd_mem_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_nack,
  output logic        busy,
  output logic        scl,
  inout  wire         sda
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, DEV_ADDR, MODE, ACK_DEV, MEM_ADDR, ACK_MEM,
    WR_HI, ACK_WR_HI, WR_LO, ACK_WR_LO,
    RD_HI, MACK_HI, RD_LO, MNACK_LO, STOP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       qtr;
  logic [2:0]       bit_cnt, bit_nxt;
  logic             rw_q;
  logic [6:0]       dev_q;
  logic [7:0]       mem_q;
  logic [15:0]      wdata_q;
  logic [15:0]      shift_q;
  logic             sda_smp;
  logic             nack_q;
  logic             sda_low;
  logic             sda_in;

  logic qtr_end, slot_end, smp_pt, ack_state;
  logic [7:0] dev_ext;

  assign sda_in    = sda;
  assign qtr_end   = (div_cnt == DIV_LAST);
  assign slot_end  = qtr_end && (qtr == 2'd3);
  assign smp_pt    = qtr_end && (qtr == 2'd2);
  assign ack_state = (state == ACK_DEV) || (state == ACK_MEM) ||
                     (state == ACK_WR_HI) || (state == ACK_WR_LO);
  assign dev_ext   = {1'b0, dev_q};

  assign cmd_ready = (state == IDLE);
  assign busy      = !cmd_ready;
  assign scl       = (state == IDLE) ? 1'b1 : qtr[1];
  assign sda       = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      mem_q     <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      sda_smp   <= 1'b0;
      nack_q    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        div_cnt <= '0;
        qtr     <= '0;
        if (cmd_valid) begin
          rw_q    <= cmd_rw;
          dev_q   <= cmd_dev_addr;
          mem_q   <= cmd_mem_addr;
          wdata_q <= cmd_wdata;
          nack_q  <= 1'b0;
        end
      end else begin
        if (qtr_end) begin
          div_cnt <= '0;
          qtr     <= qtr + 2'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (smp_pt) begin
          sda_smp <= sda_in;
          if ((state == RD_HI) || (state == RD_LO))
            shift_q <= {shift_q[14:0], sda_in};
        end
        if (slot_end) begin
          if (ack_state && sda_smp)
            nack_q <= 1'b1;
          if (state == STOP) begin
            rsp_valid <= 1'b1;
            rsp_nack  <= nack_q;
            // read data is only published when the whole read succeeded
            if (rw_q && !nack_q)
              rsp_rdata <= shift_q;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    if (state == IDLE) begin
      if (cmd_valid)
        state_nxt = START;
    end else if (slot_end) begin
      case (state)
        START:     begin state_nxt = DEV_ADDR; bit_nxt = 3'd6; end
        DEV_ADDR:  if (bit_cnt == 3'd0) state_nxt = MODE;
                   else bit_nxt = bit_cnt - 3'd1;
        MODE:      state_nxt = ACK_DEV;
        ACK_DEV:   if (sda_smp) state_nxt = STOP;
                   else begin state_nxt = MEM_ADDR; bit_nxt = 3'd7; end
        MEM_ADDR:  if (bit_cnt == 3'd0) state_nxt = ACK_MEM;
                   else bit_nxt = bit_cnt - 3'd1;
        ACK_MEM:   if (sda_smp) state_nxt = STOP;
                   else begin state_nxt = rw_q ? RD_HI : WR_HI; bit_nxt = 3'd7; end
        WR_HI:     if (bit_cnt == 3'd0) state_nxt = ACK_WR_HI;
                   else bit_nxt = bit_cnt - 3'd1;
        ACK_WR_HI: if (sda_smp) state_nxt = STOP;
                   else begin state_nxt = WR_LO; bit_nxt = 3'd7; end
        WR_LO:     if (bit_cnt == 3'd0) state_nxt = ACK_WR_LO;
                   else bit_nxt = bit_cnt - 3'd1;
        ACK_WR_LO: state_nxt = STOP;
        RD_HI:     if (bit_cnt == 3'd0) state_nxt = MACK_HI;
                   else bit_nxt = bit_cnt - 3'd1;
        MACK_HI:   begin state_nxt = RD_LO; bit_nxt = 3'd7; end
        RD_LO:     if (bit_cnt == 3'd0) state_nxt = MNACK_LO;
                   else bit_nxt = bit_cnt - 3'd1;
        MNACK_LO:  state_nxt = STOP;
        STOP:      state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // SDA only ever changes with the slot, except the START/STOP edges at q3 entry
  always_comb begin
    sda_low = 1'b0;
    case (state)
      START:    sda_low = (qtr == 2'd3);
      DEV_ADDR: sda_low = !dev_ext[bit_cnt];
      MODE:     sda_low = !rw_q;
      MEM_ADDR: sda_low = !mem_q[bit_cnt];
      WR_HI:    sda_low = !wdata_q[{1'b1, bit_cnt}];
      WR_LO:    sda_low = !wdata_q[{1'b0, bit_cnt}];
      MACK_HI:  sda_low = 1'b1;
      STOP:     sda_low = (qtr != 2'd3);
      default:  sda_low = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_i2c_sram_master.sv
// Bench for i2c_sram_master: behavioural SRAM slave on the bus, response scoreboard, second instance at CLK_DIV=1.
module tb_i2c_sram_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid, cmd_rw;
  logic [6:0]  cmd_dev_addr;
  logic [7:0]  cmd_mem_addr;
  logic [15:0] cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_nack, busy, scl;
  logic [15:0] rsp_rdata;
  wire         sda;
  logic        s_drv;

  logic        cmd1_valid, cmd1_ready, rsp1_valid, rsp1_nack, busy1, scl1;
  logic [15:0] rsp1_rdata;
  wire         sda1;
  logic        s1_drv;

  assign sda  = s_drv  ? 1'b0 : 1'bz;
  assign sda1 = s1_drv ? 1'b0 : 1'bz;
  pullup (sda);
  pullup (sda1);

  i2c_sram_master #(.CLK_DIV(4)) u_dut (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_dev_addr(cmd_dev_addr), .cmd_mem_addr(cmd_mem_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_nack(rsp_nack), .busy(busy), .scl(scl), .sda(sda)
  );

  i2c_sram_master #(.CLK_DIV(1)) u_dut_div1 (
    .clk(clk), .reset(rst_n), .cmd_valid(cmd1_valid), .cmd_ready(cmd1_ready),
    .cmd_rw(cmd_rw), .cmd_dev_addr(cmd_dev_addr), .cmd_mem_addr(cmd_mem_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp1_valid), .rsp_rdata(rsp1_rdata),
    .rsp_nack(rsp1_nack), .busy(busy1), .scl(scl1), .sda(sda1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_rsp = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        nack;
    logic [15:0] rdata;
    int          lat;
  } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];

  // response scoreboard
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc_q.delete();
      end else begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            check("spurious_rsp", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            a = (acc_q.size() > 0) ? acc_q.pop_front() : -1;
            check("rsp_nack", 32'(rsp_nack), 32'(e.nack));
            check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            check("rsp_latency", 32'(cyc - a), 32'(e.lat));
          end
        end
      end
    end
  end

  // SRAM slave model: slot 0..7 addr+mode, 8 ack, 9..16 mem, 17 ack, 18..25 hi, 26 ack, 27..34 lo, 35 ack
  logic [6:0]  s_addr;
  logic [7:0]  s_dev, s_mem, s_hi, s_lo;
  logic        s_rw, s_mack, s_mnack;
  logic [15:0] s_rd;
  logic [15:0] s_mem_arr [256];

  initial begin
    logic sc, sd, scp, sdp, act;
    int   slot;
    logic [7:0] sh;
    s_drv = 1'b0; scp = 1'b1; sdp = 1'b1; act = 1'b0; slot = 0; sh = '0;
    s_dev = '0; s_mem = '0; s_hi = '0; s_lo = '0; s_rw = 1'b0; s_rd = '0;
    s_mack = 1'b1; s_mnack = 1'b0;
    for (int i = 0; i < 256; i++) s_mem_arr[i] = '0;
    forever begin
      @(negedge clk);
      sc = scl; sd = sda;
      if (sc && scp && sdp && !sd) begin
        act = 1'b1; slot = -1;
      end else if (sc && scp && !sdp && sd) begin
        act = 1'b0; s_drv = 1'b0;
      end else if (act && sc && !scp) begin
        sh = {sh[6:0], sd};
        case (slot)
          7:  begin s_dev = sh; s_rw = sd; end
          16: s_mem = sh;
          25: s_hi = sh;
          26: s_mack = sd;
          34: begin s_lo = sh; if (!s_rw) s_mem_arr[s_mem] = {s_hi, sh}; end
          35: s_mnack = sd;
          default: ;
        endcase
      end else if (act && !sc && scp) begin
        slot++;
        s_drv = 1'b0;
        if (slot == 8) begin
          if (s_dev[7:1] == s_addr) s_drv = 1'b1;
          else act = 1'b0;
        end else if (slot == 17) begin
          s_drv = 1'b1;
          s_rd  = s_mem_arr[s_mem];
        end else if (!s_rw && (slot == 26 || slot == 35)) begin
          s_drv = 1'b1;
        end else if (s_rw && slot >= 18 && slot <= 25) begin
          s_drv = !s_rd[15 - (slot - 18)];
        end else if (s_rw && slot >= 27 && slot <= 34) begin
          s_drv = !s_rd[7 - (slot - 27)];
        end
      end
      scp = sc; sdp = sd;
    end
  end

  // always-ACK slave and SCL phase-length monitor for the CLK_DIV=1 instance
  int ph_n = 0;
  int ph_bad = 0;
  initial begin
    logic sc, sd, scp, sdp, act, armed;
    int   slot, last;
    s1_drv = 1'b0; scp = 1'b1; sdp = 1'b1; act = 1'b0; armed = 1'b0; slot = 0; last = 0;
    forever begin
      @(negedge clk);
      sc = scl1; sd = sda1;
      if (sc != scp) begin
        if (armed) begin
          ph_n++;
          if (cyc - last != 2) ph_bad++;
        end
        armed = 1'b1;
        last  = cyc;
      end
      if (rsp1_valid) armed = 1'b0;
      if (sc && scp && sdp && !sd) begin
        act = 1'b1; slot = -1;
      end else if (sc && scp && !sdp && sd) begin
        act = 1'b0; s1_drv = 1'b0;
      end else if (act && !sc && scp) begin
        slot++;
        s1_drv = (slot == 8 || slot == 17 || slot == 26 || slot == 35);
      end
      scp = sc; sdp = sd;
    end
  end

  task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] mem,
                      input logic [15:0] wd, input bit push, input logic nack,
                      input logic [15:0] rdata, input int lat);
    exp_t e;
    cmd_rw = rw; cmd_dev_addr = dev; cmd_mem_addr = mem; cmd_wdata = wd;
    cmd_valid = 1'b1;
    if (push) begin
      e.nack = nack; e.rdata = rdata; e.lat = lat;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid    = 1'b0;
    cmd_rw       = 1'($urandom);
    cmd_dev_addr = 7'($urandom);
    cmd_mem_addr = 8'($urandom);
    cmd_wdata    = 16'($urandom);
  endtask

  task automatic wait_rsp(input int budget);
    int i;
    i = 0;
    while (!rsp_valid && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check("rsp_wait", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    logic [15:0] last_rdata;
    int a1, r1;
    last_rdata = 16'h0000;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd1_valid = 1'b0;
    cmd_rw = 1'b0; cmd_dev_addr = '0; cmd_mem_addr = '0; cmd_wdata = '0;
    s_addr = 7'h2A;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_nack", 32'(rsp_nack), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // write 0xBEEF to 0x10 on device 0x2A
    send(1'b0, 7'h2A, 8'h10, 16'hBEEF, 1'b1, 1'b0, last_rdata, 609);
    wait_rsp(800);
    @(posedge clk); #1;
    check("wr_bus_dev_mode", 32'(s_dev), 32'h54);
    check("wr_bus_mem", 32'(s_mem), 32'h10);
    check("wr_bus_hi", 32'(s_hi), 32'hBE);
    check("wr_bus_lo", 32'(s_lo), 32'hEF);
    check("wr_slave_mem", 32'(s_mem_arr[8'h10]), 32'hBEEF);

    // read it back, with a command held on cmd_valid while busy
    s_mack = 1'b1; s_mnack = 1'b0;
    send(1'b1, 7'h2A, 8'h10, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 609);
    last_rdata = 16'hBEEF;
    cmd_valid = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_rsp(800);
    @(posedge clk); #1;
    check("rd_mack_hi_sda", 32'(s_mack), 32'd0);
    check("rd_mnack_lo_sda", 32'(s_mnack), 32'd1);

    // wrong device address: NACK at ACK_DEV
    s_addr = 7'h2B;
    send(1'b0, 7'h2A, 8'h20, 16'h1111, 1'b1, 1'b1, last_rdata, 177);
    wait_rsp(800);
    check("nack_scl_idle", 32'(scl), 32'd1);
    check("nack_sda_idle", 32'(sda), 32'd1);
    @(posedge clk); #1;
    check("nack_no_write", 32'(s_mem_arr[8'h20]), 32'h0000);
    s_addr = 7'h2A;

    // back-to-back write then read of 0xFF
    send(1'b0, 7'h2A, 8'hFF, 16'h1234, 1'b1, 1'b0, last_rdata, 609);
    wait_rsp(800);
    check("b2b_ready_in_rsp", 32'(cmd_ready), 32'd1);
    begin
      exp_t e;
      cmd_rw = 1'b1; cmd_dev_addr = 7'h2A; cmd_mem_addr = 8'hFF; cmd_valid = 1'b1;
      e.nack = 1'b0; e.rdata = 16'h1234; e.lat = 609;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("b2b_start_scl", 32'(scl), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    last_rdata = 16'h1234;
    wait_rsp(800);
    @(posedge clk); #1;

    // reset during WR_LO (slot 30 of the write)
    send(1'b0, 7'h2A, 8'h40, 16'hCAFE, 1'b0, 1'b0, 16'h0000, 0);
    repeat (488) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_scl", 32'(scl), 32'd1);
    check("midrst_sda", 32'(sda), 32'd1);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rdata = 16'h0000;
    check("midrst_no_write", 32'(s_mem_arr[8'h40]), 32'h0000);
    repeat (2) @(posedge clk);
    #1;

    // normal traffic after reset
    send(1'b0, 7'h2A, 8'h33, 16'h5A5A, 1'b1, 1'b0, last_rdata, 609);
    wait_rsp(800);
    @(posedge clk); #1;
    send(1'b1, 7'h2A, 8'h33, 16'h0000, 1'b1, 1'b0, 16'h5A5A, 609);
    wait_rsp(800);
    @(posedge clk); #1;

    // CLK_DIV=1 instance
    cmd_rw = 1'b0; cmd_dev_addr = 7'h2A; cmd_mem_addr = 8'h01; cmd_wdata = 16'hA55A;
    cmd1_valid = 1'b1;
    a1 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      a1 = cyc;
      if (cmd1_ready) break;
    end
    @(posedge clk); #1;
    cmd1_valid = 1'b0;
    r1 = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rsp1_valid) begin
        r1 = cyc;
        break;
      end
    end
    check("div1_rsp_seen", 32'(rsp1_valid), 32'd1);
    check("div1_latency", 32'(r1 - a1), 32'd153);
    check("div1_nack", 32'(rsp1_nack), 32'd0);
    check("div1_phase_count", 32'(ph_n), 32'd75);
    check("div1_phase_bad", 32'(ph_bad), 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("rsp_count", 32'(n_rsp), 32'd7);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
